// File: rtl/ob_stream_reader.sv
// Output-buffer reader: drains a row region of the SRAM into a valid/ready stream.
// Define OB_STREAM_READER_CLEAR_EN to follow every read with a zero write (read-and-clear).
module ob_stream_reader #(
    parameter int WIDTH  = 8,
    parameter int COL    = 4,
    parameter int O_SIZE = 512,
    localparam int AW = $clog2(O_SIZE),
    localparam int DW = COL * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          mem_cenb_o,
    output logic          mem_wenb_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_d_o,
    input  logic [DW-1:0] mem_data_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued;
    logic [AW:0]   issued_nx;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] fifo_data [3];
    logic [2:0]    fifo_last;
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr;
    logic [1:0]    count;
    logic [2:0]    occ;
    logic          last_seen;
    logic          wr_pend;
    logic          issue;
    logic          push;
    logic          pop;
    logic          pop_last;
    logic          fin;
    logic [AW-1:0] rd_addr;

    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base, input logic [AW:0] ofs);
        logic [AW+1:0] sum;
        sum = {2'b00, base} + {1'b0, ofs};
        if (sum >= (AW+2)'(O_SIZE))
            sum = sum - (AW+2)'(O_SIZE);
        return sum[AW-1:0];
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit = rows parked in the FIFO plus the read whose data is still on the SRAM bus;
    // only registered state feeds the issue decision, so ready_i never reaches mem_*.
    assign occ       = {1'b0, count} + {2'b00, inflight};
    assign issued_nx = issued + (AW+1)'(1);
    assign issue     = (state == S_READ) && (issued < len_q) && (occ < 3'd3) && !wr_pend;
    assign push      = inflight;
    assign valid_o   = (count != 2'd0);
    assign pop       = valid_o && ready_i;
    assign pop_last  = pop && fifo_last[rd_ptr];
    assign fin       = (pop_last || last_seen) && !wr_pend;
    assign data_o    = valid_o ? fifo_data[rd_ptr] : '0;
    assign last_o    = valid_o && fifo_last[rd_ptr];
    assign busy_o    = (state != S_IDLE);
    assign rd_addr   = wrap_addr(base_q, issued);
    assign mem_d_o   = '0;

`ifdef OB_STREAM_READER_CLEAR_EN
    logic [AW-1:0] wr_addr;

    assign mem_cenb_o = !(issue || wr_pend);
    assign mem_wenb_o = !wr_pend;
    assign mem_addr_o = wr_pend ? wr_addr : (issue ? rd_addr : '0);

    // The write slot directly after each read zeroes the row just fetched.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            wr_pend <= 1'b0;
        else
            wr_pend <= issue;
        wr_addr <= rd_addr;
    end
`else
    assign wr_pend    = 1'b0;
    assign mem_cenb_o = !issue;
    assign mem_wenb_o = 1'b1;
    assign mem_addr_o = issue ? rd_addr : '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            issued    <= '0;
            inflight  <= 1'b0;
            count     <= 2'd0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            done_o    <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= issue;
            if (issue)
                issued <= issued_nx;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            base_q    <= base_addr_i;
                            len_q     <= len_i;
                            issued    <= '0;
                            last_seen <= 1'b0;
                            state     <= S_READ;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue && (issued_nx == len_q))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop_last)
                        last_seen <= 1'b1;
                    if (fin) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read return lands in the FIFO one cycle after issue, tagged if it is the final row.
    always_ff @(posedge clk_i) begin
        inflight_last <= issue && (issued_nx == len_q);
        if (push) begin
            fifo_data[wr_ptr] <= mem_data_i;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

    overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count == 2'd3)));

endmodule

// File: tb/tb_ob_stream_reader.sv
// Scoreboard bench for ob_stream_reader: SRAM model, randomized backpressure, queue-based reference.
module tb_ob_stream_reader;
    localparam int WIDTH  = 8;
    localparam int COL    = 4;
    localparam int O_SIZE = 512;
    localparam int AW     = $clog2(O_SIZE);
    localparam int DW     = WIDTH * COL;
`ifdef OB_STREAM_READER_CLEAR_EN
    localparam int STEP = 2;
    localparam bit CLR  = 1'b1;
`else
    localparam int STEP = 1;
    localparam bit CLR  = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } row_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, mem_cenb_o, mem_wenb_o, valid_o, last_o;
    logic          ready_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_d_o, data_o;
    logic [DW-1:0] mem_data_i = '0;

    ob_stream_reader #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .mem_cenb_o(mem_cenb_o),
        .mem_wenb_o(mem_wenb_o), .mem_addr_o(mem_addr_o), .mem_d_o(mem_d_o),
        .mem_data_i(mem_data_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .last_o(last_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] sram    [O_SIZE];
    logic [DW-1:0] ref_mem [O_SIZE];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    // SRAM model: one-cycle read latency, garbage on the bus when no read was issued.
    always @(posedge clk_i) begin
        if (!mem_cenb_o && mem_wenb_o) mem_data_i <= sram[mem_addr_o];
        else                           mem_data_i <= DW'($urandom);
        if (!mem_cenb_o && !mem_wenb_o) sram[mem_addr_o] <= mem_d_o;
        else if (tb_we)                 sram[tb_waddr]   <= tb_wdata;
    end

    int   checks = 0, passes = 0;
    int   hs_count = 0, done_count = 0, outstanding = 0;
    int   rmode = 0;
    row_t exp_q[$];
    logic [AW-1:0] addr_q[$];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    // Ready driver: 0 = always high, 1 = fixed pattern with a 5-cycle stall, 2 = random.
    initial begin
        bit pat [16] = '{1,0,0,1,0,0,1,0,0,0,0,0,1,0,0,1};
        int pidx = 0;
        forever begin
            @(posedge clk_i); #1;
            case (rmode)
                0: ready_i = 1'b1;
                1: begin ready_i = pat[pidx]; pidx = (pidx + 1) % 16; end
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and every read issued.
    initial begin
        bit prev_stall = 0, prev_rd = 0, prev_last = 0, rd, hs;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] prev_addr = '0, a;
        row_t r;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 0; prev_rd = 0; outstanding = 0;
            end else begin
                if (done_o) done_count++;
                if (prev_stall)
                    check(valid_o && data_o == prev_data && last_o == prev_last, "stall_hold",
                          64'({valid_o, last_o, data_o}), 64'({1'b1, prev_last, prev_data}));
                rd = !mem_cenb_o && mem_wenb_o;
                hs = valid_o && ready_i;
                if (prev_rd) begin
                    if (CLR)
                        check(!mem_cenb_o && !mem_wenb_o && mem_addr_o == prev_addr, "clear_write",
                              64'({mem_cenb_o, mem_wenb_o, mem_addr_o}), 64'({2'b00, prev_addr}));
                    else
                        check(mem_wenb_o == 1'b1, "no_write", 64'(mem_wenb_o), 64'(1));
                end
                if (rd) begin
                    check(outstanding < 3, "credit", 64'(outstanding), 64'(2));
                    if (addr_q.size() == 0) check(1'b0, "extra_read", 64'(mem_addr_o), 64'(0));
                    else begin
                        a = addr_q.pop_front();
                        check(mem_addr_o == a, "rd_addr", 64'(mem_addr_o), 64'(a));
                    end
                end
                if (hs) begin
                    if (exp_q.size() == 0) check(1'b0, "extra_row", 64'(data_o), 64'(0));
                    else begin
                        r = exp_q.pop_front();
                        check(data_o == r.data && last_o == r.last, "row",
                              64'({last_o, data_o}), 64'({r.last, r.data}));
                    end
                    hs_count++;
                end
                outstanding = outstanding + (rd ? 1 : 0) - (hs ? 1 : 0);
                prev_stall = valid_o && !ready_i;
                prev_data  = data_o;
                prev_last  = last_o;
                prev_rd    = rd;
                prev_addr  = mem_addr_o;
            end
        end
    end

    task automatic init_rows(input int base, input int len, input bit ramp);
        logic [DW-1:0] v;
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % O_SIZE;
            if (ramp) for (int j = 0; j < COL; j++) v[j*WIDTH +: WIDTH] = WIDTH'(COL * i + j);
            else v = DW'($urandom);
            ref_mem[a] = v;
            @(negedge clk_i);
            tb_we = 1'b1; tb_waddr = AW'(a); tb_wdata = v;
        end
        @(negedge clk_i);
        tb_we = 1'b0;
    endtask

    task automatic push_expect(input int base, input int len);
        row_t r;
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % O_SIZE;
            addr_q.push_back(AW'(a));
            r.data = ref_mem[a];
            r.last = (i == len - 1);
            exp_q.push_back(r);
            if (CLR) ref_mem[a] = '0;
        end
    endtask

    task automatic start_xfer(input int base, input int len, input bit expect_it);
        @(negedge clk_i);
        base_addr_i = AW'(base); len_i = (AW+1)'(len); start_i = 1'b1;
        if (expect_it) push_expect(base, len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit got = 0;
        for (int n = 0; n < max && !got; n++) begin
            @(negedge clk_i);
            if (done_o) got = 1;
        end
        check(got, "done_seen", 64'(got), 64'(1));
    endtask

    task automatic finish_checks(input int base, input int len);
        int bad = 0, a;
        check(exp_q.size() == 0, "rows_left", 64'(exp_q.size()), 64'(0));
        check(addr_q.size() == 0, "reads_left", 64'(addr_q.size()), 64'(0));
        for (int i = 0; i < len; i++) begin
            a = (base + i) % O_SIZE;
            if (sram[a] !== ref_mem[a]) bad++;
        end
        check(bad == 0, "mem_region", 64'(bad), 64'(0));
        repeat (2) begin
            @(negedge clk_i);
            check(mem_cenb_o && !valid_o && !busy_o, "idle_after",
                  64'({mem_cenb_o, valid_o, busy_o}), 64'(3'b100));
        end
    endtask

    task automatic check_reset_outputs();
        check(busy_o == 0, "rst_busy", 64'(busy_o), 64'(0));
        check(done_o == 0, "rst_done", 64'(done_o), 64'(0));
        check(valid_o == 0, "rst_valid", 64'(valid_o), 64'(0));
        check(last_o == 0, "rst_last", 64'(last_o), 64'(0));
        check(data_o == '0, "rst_data", 64'(data_o), 64'(0));
        check(mem_cenb_o == 1, "rst_cenb", 64'(mem_cenb_o), 64'(1));
        check(mem_wenb_o == 1, "rst_wenb", 64'(mem_wenb_o), 64'(1));
        check(mem_addr_o == '0, "rst_addr", 64'(mem_addr_o), 64'(0));
        check(mem_d_o == '0, "rst_d", 64'(mem_d_o), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", checks);
        $fatal(1);
    end

    initial begin
        int dc0, hs0, base, len, n;
        bit ev;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs();

        // Cycle-exact transfer of rows 0..3 with ready held high, then read back.
        rmode = 0;
        init_rows(0, 4, 1'b1);
        start_xfer(0, 4, 1'b1);
        for (int k = 1; k <= 4 + 3 * STEP; k++) begin
            @(negedge clk_i);
            ev = (k >= 3) && ((k - 3) % STEP == 0) && ((k - 3) / STEP < 4);
            check(valid_o == ev, "t_valid", 64'(valid_o), 64'(ev));
            check(last_o == (k == 3 + 3 * STEP), "t_last", 64'(last_o), 64'(k == 3 + 3 * STEP));
            check(done_o == (k == 4 + 3 * STEP), "t_done", 64'(done_o), 64'(k == 4 + 3 * STEP));
            check(busy_o == (k < 4 + 3 * STEP), "t_busy", 64'(busy_o), 64'(k < 4 + 3 * STEP));
            if (k == 1)
                check(!mem_cenb_o && mem_addr_o == '0, "t_first_rd",
                      64'({mem_cenb_o, mem_addr_o}), 64'(0));
        end
        finish_checks(0, 4);
        start_xfer(0, 4, 1'b1);
        wait_done(60);
        finish_checks(0, 4);

        // Backpressure pattern including a 5-cycle stall.
        rmode = 1;
        init_rows(0, 12, 1'b1);
        start_xfer(0, 12, 1'b1);
        wait_done(200);
        finish_checks(0, 12);

        // Address wrap at the top of the memory.
        rmode = 2;
        init_rows(O_SIZE - 2, 4, 1'b0);
        start_xfer(O_SIZE - 2, 4, 1'b1);
        wait_done(100);
        finish_checks(O_SIZE - 2, 4);

        // Zero-length request.
        start_xfer(33, 0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            check(done_o == (k == 1), "len0_done", 64'(done_o), 64'(k == 1));
            check(mem_cenb_o && !valid_o && !busy_o, "len0_idle",
                  64'({mem_cenb_o, valid_o, busy_o}), 64'(3'b100));
        end

        // Start pulsed while busy must be ignored.
        rmode = 1;
        init_rows(20, 6, 1'b0);
        dc0 = done_count;
        start_xfer(20, 6, 1'b1);
        repeat (3) @(negedge clk_i);
        base_addr_i = AW'(100); len_i = (AW+1)'(3); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(200);
        finish_checks(20, 6);
        check(done_count == dc0 + 1, "busy_start_done", 64'(done_count - dc0), 64'(1));

        // Reset after two of four rows, then a fresh transfer from the same base.
        rmode = 0;
        init_rows(40, 4, 1'b0);
        hs0 = hs_count;
        start_xfer(40, 4, 1'b1);
        n = 0;
        while (hs_count < hs0 + 2 && n < 50) begin @(posedge clk_i); n++; end
        check(hs_count >= hs0 + 2, "rst_two_rows", 64'(hs_count - hs0), 64'(2));
        #1 rst_i = 1'b1;
        dc0 = done_count;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk_i);
        check_reset_outputs();
        repeat (3) begin
            @(negedge clk_i);
            check(!done_o && !valid_o && !busy_o, "rst_quiet",
                  64'({done_o, valid_o, busy_o}), 64'(0));
        end
        check(done_count == dc0, "rst_no_done", 64'(done_count - dc0), 64'(0));
        init_rows(40, 4, 1'b0);
        start_xfer(40, 4, 1'b1);
        wait_done(60);
        finish_checks(40, 4);

        // Randomized transfers and backpressure.
        for (int it = 0; it < 20; it++) begin
            rmode = $urandom_range(0, 2);
            base  = $urandom_range(0, O_SIZE - 1);
            len   = (it % 5 == 4) ? $urandom_range(20, 40) : $urandom_range(1, 10);
            init_rows(base, len, 1'b0);
            start_xfer(base, len, 1'b1);
            wait_done(len * 8 + 40);
            finish_checks(base, len);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
